// File: rtl/state_sequencer.sv
// Table-driven Moore sequencer: walks NUM_STATES run states, each held for dwell+1 cycles,
// with one-shot/loop operation, hold and stop. out is decoded from state; out_val is registered.
module state_sequencer #(
   parameter  int                          NUM_STATES = 4,
   parameter  int                          OUT_W      = 2,
   parameter  int                          VAL_W      = 3,
   parameter  int                          CNT_W      = 8,
   parameter  logic [NUM_STATES*OUT_W-1:0] OUT_TABLE  = 8'h2D,
   parameter  logic [NUM_STATES*VAL_W-1:0] VAL_TABLE  = 12'h3A2,
   parameter  logic [OUT_W-1:0]            IDLE_OUT   = {OUT_W{1'b0}},
   parameter  logic [VAL_W-1:0]            IDLE_VAL   = {VAL_W{1'b0}},
   localparam int                          IDX_W      = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             loop_en,
   input  logic [CNT_W-1:0] dwell,
   output logic             active,
   output logic [IDX_W-1:0] cur_state,
   output logic [OUT_W-1:0] out,
   output logic [VAL_W-1:0] out_val,
   output logic             step,
   output logic             done
);

   typedef enum logic {
      PH_IDLE = 1'b0,
      PH_RUN  = 1'b1
   } phase_t;

   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STATES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   phase_t           phase_r;
   logic [IDX_W-1:0] idx_r;
   logic [CNT_W-1:0] cnt_r;
   logic [VAL_W-1:0] out_val_r;
   logic             step_r;
   logic             done_r;
   logic [OUT_W-1:0] out_s;

   function automatic logic [OUT_W-1:0] out_code(input logic [IDX_W-1:0] idx);
      return OUT_TABLE[int'(idx)*OUT_W +: OUT_W];
   endfunction

   function automatic logic [VAL_W-1:0] val_code(input logic [IDX_W-1:0] idx);
      return VAL_TABLE[int'(idx)*VAL_W +: VAL_W];
   endfunction

   // Sequencer state, dwell counter and registered outputs; priority stop > hold > advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_r   <= PH_IDLE;
         idx_r     <= IDX_ZERO;
         cnt_r     <= CNT_ZERO;
         out_val_r <= IDLE_VAL;
         step_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         step_r    <= 1'b0;
         done_r    <= 1'b0;
         out_val_r <= (phase_r == PH_RUN) ? val_code(idx_r) : IDLE_VAL;
         case (phase_r)
            PH_IDLE: begin
               idx_r <= IDX_ZERO;
               if (start && !stop) begin
                  phase_r <= PH_RUN;
                  cnt_r   <= dwell;
               end else begin
                  cnt_r   <= CNT_ZERO;
               end
            end
            PH_RUN: begin
               if (stop) begin
                  phase_r <= PH_IDLE;
                  idx_r   <= IDX_ZERO;
                  cnt_r   <= CNT_ZERO;
               end else if (hold) begin
                  cnt_r   <= cnt_r;
               end else if (cnt_r != CNT_ZERO) begin
                  cnt_r   <= cnt_r - CNT_ONE;
               end else if (idx_r != IDX_LAST) begin
                  idx_r   <= idx_r + IDX_ONE;
                  cnt_r   <= dwell;
                  step_r  <= 1'b1;
               end else if (loop_en) begin
                  idx_r   <= IDX_ZERO;
                  cnt_r   <= dwell;
                  step_r  <= 1'b1;
               end else begin
                  phase_r <= PH_IDLE;
                  idx_r   <= IDX_ZERO;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               phase_r <= PH_IDLE;
               idx_r   <= IDX_ZERO;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

   // Output code is a pure decode of the registered state.
   always_comb begin
      out_s = IDLE_OUT;
      if (phase_r == PH_RUN) begin
         out_s = out_code(idx_r);
      end else begin
         out_s = IDLE_OUT;
      end
   end

   assign active    = (phase_r == PH_RUN);
   assign cur_state = idx_r;
   assign out       = out_s;
   assign out_val   = out_val_r;
   assign step      = step_r;
   assign done      = done_r;

endmodule
